// File: rtl/gpio_pad_sequencer_if.sv
// Request channel from the core GPIO register block to the pad sequencer.
// The register block (master) offers a direction/data pair. The sequencer
// (slave) accepts it when it is ready.
interface gpio_pad_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_dir;
  logic [WIDTH-1:0] req_data;

  modport master (
    output req_valid,
    output req_dir,
    output req_data,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_dir,
    input  req_data,
    output req_ready
  );
endinterface

// File: rtl/gpio_pad_sequencer.sv
// GPIO pad sequencer. It drives the o/oe/ie controls of a bank of
// bidirectional pad cells. Pads that change direction pass through a
// break-before-make window with both oe and ie low. They then wait in a
// settle window while the input synchronizer refills. Synchronized input
// edges are reported, except on pads that are still turning, so a
// direction change never appears as a false edge.
module gpio_pad_sequencer #(
  parameter int WIDTH       = 8,
  parameter int TURN_CYCLES = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  gpio_pad_sequencer_if.slave     req,
  output logic [WIDTH-1:0]        cell_o,
  output logic [WIDTH-1:0]        cell_oe,
  output logic [WIDTH-1:0]        cell_ie,
  input  logic [WIDTH-1:0]        cell_i,
  output logic [WIDTH-1:0]        rd_data,
  output logic [WIDTH-1:0]        rise_evt,
  output logic [WIDTH-1:0]        fall_evt,
  output logic                    busy
);

  // The counter must hold both the quiesce reload and the settle reload.
  localparam int CNT_MAX = (TURN_CYCLES > SYNC_STAGES) ? TURN_CYCLES : SYNC_STAGES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] TURN_LOAD   = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SYNC_STAGES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_QUIESCE = 2'd1,
    S_SETTLE  = 2'd2
  } state_t;

  // Sequencer registers
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_o;
  logic [WIDTH-1:0] r_oe;
  logic [WIDTH-1:0] r_ie;
  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_turn;

  // Input path registers
  logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0]                  r_prev;
  logic [WIDTH-1:0]                  r_rise;
  logic [WIDTH-1:0]                  r_fall;

  // Next-state values
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_o_nxt;
  logic [WIDTH-1:0] w_oe_nxt;
  logic [WIDTH-1:0] w_ie_nxt;
  logic [WIDTH-1:0] w_dir_nxt;
  logic [WIDTH-1:0] w_turn_nxt;

  logic             w_ready;
  logic             w_take;
  logic [WIDTH-1:0] w_turn_req;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_sync;

  // The request is only looked at in IDLE. Holding it while busy is the
  // requester's job.
  assign w_ready    = (r_state == S_IDLE) && !reset;
  assign w_take     = req.req_valid && w_ready;
  assign w_turn_req = req.req_dir ^ r_oe;

  // Turning pads are hidden from edge detection for the whole sequence.
  assign w_mask = (r_state == S_IDLE) ? {WIDTH{1'b0}} : r_turn;
  assign w_sync = r_sync[SYNC_STAGES-1];

  // Next-state, counter and pad-control decode for the direction sequencer
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_o_nxt     = r_o;
    w_oe_nxt    = r_oe;
    w_ie_nxt    = r_ie;
    w_dir_nxt   = r_dir;
    w_turn_nxt  = r_turn;

    case (r_state)
      S_IDLE: begin
        if (w_take) begin
          // Output values go out immediately, even on pads that are turning.
          // They stay invisible until oe rises.
          w_o_nxt    = req.req_data;
          w_dir_nxt  = req.req_dir;
          w_turn_nxt = w_turn_req;
          if (w_turn_req != {WIDTH{1'b0}}) begin
            // Break: release both drive and receive on the turning pads.
            w_oe_nxt    = r_oe & ~w_turn_req;
            w_ie_nxt    = r_ie & ~w_turn_req;
            w_state_nxt = S_QUIESCE;
            w_cnt_nxt   = TURN_LOAD;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_QUIESCE: begin
        if (r_cnt == {CNT_W{1'b0}}) begin
          // Make: apply the new direction to every pad at once.
          w_oe_nxt    = r_dir;
          w_ie_nxt    = ~r_dir;
          w_state_nxt = S_SETTLE;
          w_cnt_nxt   = SETTLE_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end

      S_SETTLE: begin
        // Wait until the synchronizer has flushed the pre-turn samples.
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_ONE;
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Sequencer state, counter and pad-control registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= {CNT_W{1'b0}};
      r_o     <= {WIDTH{1'b0}};
      r_oe    <= {WIDTH{1'b0}};
      r_ie    <= {WIDTH{1'b1}};
      r_dir   <= {WIDTH{1'b0}};
      r_turn  <= {WIDTH{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_o     <= w_o_nxt;
      r_oe    <= w_oe_nxt;
      r_ie    <= w_ie_nxt;
      r_dir   <= w_dir_nxt;
      r_turn  <= w_turn_nxt;
    end
  end

  // Synchronizer chain for cell_i and the previous-sample register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= {WIDTH{1'b0}};
    end else begin
      r_sync[0] <= cell_i;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
      // prev keeps tracking while masked, so no stale edge survives the mask.
      r_prev <= w_sync;
    end
  end

  // Registered edge events on receiving, non-turning pads
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rise <= {WIDTH{1'b0}};
      r_fall <= {WIDTH{1'b0}};
    end else begin
      r_rise <= w_sync & ~r_prev & r_ie & ~w_mask;
      r_fall <= ~w_sync & r_prev & r_ie & ~w_mask;
    end
  end

  assign req.req_ready = w_ready;
  assign busy          = (r_state != S_IDLE);
  assign cell_o        = r_o;
  assign cell_oe       = r_oe;
  assign cell_ie       = r_ie;
  assign rd_data       = w_sync & r_ie;
  assign rise_evt      = r_rise;
  assign fall_evt      = r_fall;

endmodule

// File: tb/tb_gpio_pad_sequencer.sv
// Self-checking bench for gpio_pad_sequencer. It has three parts:
//  - a vector table for reset, turn timing, back-to-back and reset-in-quiesce
//  - hand sequences for input edges and masked direction turns
//  - random traffic, with a timeline reference model checking every cycle
// The pad cell returns 0 while its ie is low, so cell_i = ext & cell_ie.
module tb_gpio_pad_sequencer;
  localparam int W    = 8;
  localparam int TURN = 2;
  localparam int SYNC = 2;
  localparam int HIST = 4096;

  logic         clock;
  logic         reset;
  logic [W-1:0] cell_o, cell_oe, cell_ie, cell_i;
  logic [W-1:0] rd_data, rise_evt, fall_evt;
  logic [W-1:0] ext;
  logic         busy;

  gpio_pad_sequencer_if #(.WIDTH(W)) req_if ();

  assign cell_i = ext & cell_ie;

  gpio_pad_sequencer #(.WIDTH(W), .TURN_CYCLES(TURN), .SYNC_STAGES(SYNC)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req_if),
    .cell_o   (cell_o),
    .cell_oe  (cell_oe),
    .cell_ie  (cell_ie),
    .cell_i   (cell_i),
    .rd_data  (rd_data),
    .rise_evt (rise_evt),
    .fall_evt (fall_evt),
    .busy     (busy)
  );

  int checks   = 0;
  int failures = 0;
  int mcyc     = 0;

  initial clock = 1'b1;
  always #5 clock = ~clock;

  // Cycle k runs from rising edge k-1 to rising edge k.
  always @(posedge clock) mcyc++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Pad controls follow from when the last turning request was taken. The
  // synchronized input is cell_i from SYNC cycles earlier.
  logic         m_on = 1'b0;
  logic [W-1:0] m_o, m_base_oe, m_base_ie, m_tdir, m_tmask, m_rise, m_fall;
  int           m_turn_t   = -1;
  int           m_last_rst = 0;
  logic [W-1:0] cin_hist [HIST];

  function automatic logic [W-1:0] m_sync(input int c);
    if (c - SYNC > m_last_rst) return cin_hist[(c - SYNC) % HIST];
    else return {W{1'b0}};
  endfunction

  // Reference model: compare this cycle, then apply the end-of-cycle rules
  always @(negedge clock) begin : model
    int           c;
    logic [W-1:0] e_oe, e_ie, e_mask, e_rd, s, p, turn;
    logic         e_busy, e_ready;
    c = mcyc;
    if (m_turn_t >= 0 && c >= m_turn_t + TURN + SYNC + 2) begin
      m_base_oe = m_tdir;
      m_base_ie = ~m_tdir;
      m_turn_t  = -1;
    end
    if (m_turn_t >= 0 && c <= m_turn_t + TURN) begin
      e_oe = m_base_oe & ~m_tmask; e_ie = m_base_ie & ~m_tmask; e_mask = m_tmask; e_busy = 1'b1;
    end else if (m_turn_t >= 0) begin
      e_oe = m_tdir; e_ie = ~m_tdir; e_mask = m_tmask; e_busy = 1'b1;
    end else begin
      e_oe = m_base_oe; e_ie = m_base_ie; e_mask = {W{1'b0}}; e_busy = 1'b0;
    end
    e_ready = !e_busy && !reset;
    cin_hist[c % HIST] = ext & e_ie;
    e_rd = m_sync(c) & e_ie;
    if (m_on) begin
      check($sformatf("model c%0d o/oe/ie/rd/rise/fall/rdy/busy", c),
            {14'd0, cell_o, cell_oe, cell_ie, rd_data, rise_evt, fall_evt, req_if.req_ready, busy},
            {14'd0, m_o, e_oe, e_ie, e_rd, m_rise, m_fall, e_ready, e_busy});
    end
    if (reset) begin
      m_on = 1'b1; m_o = '0; m_base_oe = '0; m_base_ie = '1;
      m_turn_t = -1; m_last_rst = c; m_rise = '0; m_fall = '0;
    end else begin
      s = m_sync(c);
      p = m_sync(c - 1);
      m_rise = s & ~p & e_ie & ~e_mask;
      m_fall = ~s & p & e_ie & ~e_mask;
      if (req_if.req_valid && e_ready) begin
        turn = req_if.req_dir ^ e_oe;
        m_o  = req_if.req_data;
        if (turn != '0) begin
          m_turn_t = c; m_tdir = req_if.req_dir; m_tmask = turn;
        end
      end
    end
  end

  // ---------------- vector table ----------------
  typedef struct packed {
    logic         rst;
    logic         vld;
    logic [W-1:0] dir;
    logic [W-1:0] data;
    logic         chk;
    logic [W-1:0] o;
    logic [W-1:0] oe;
    logic [W-1:0] ie;
    logic         rdy;
    logic         bsy;
  } vec_t;

  localparam int NV = 27;
  vec_t vt [NV];

  int r0_cnt, r1_cnt, f_cnt;

  initial begin
    //               rst   vld   dir    data   chk   o      oe     ie     rdy   bsy
    vt[0]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b0};
    vt[2]  = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0};
    vt[3]  = vt[2];
    vt[4]  = vt[2];
    vt[5]  = vt[2];
    vt[6]  = '{1'b0, 1'b1, 8'hFF, 8'hA5, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0};
    vt[7]  = '{1'b0, 1'b0, 8'hFF, 8'hA5, 1'b1, 8'hA5, 8'h00, 8'h00, 1'b0, 1'b1};
    vt[8]  = vt[7];
    vt[9]  = '{1'b0, 1'b0, 8'hFF, 8'hA5, 1'b1, 8'hA5, 8'hFF, 8'h00, 1'b0, 1'b1};
    vt[10] = vt[9];
    vt[11] = vt[9];
    vt[12] = '{1'b0, 1'b1, 8'hFF, 8'h01, 1'b1, 8'hA5, 8'hFF, 8'h00, 1'b1, 1'b0};
    vt[13] = '{1'b0, 1'b1, 8'hFF, 8'h02, 1'b1, 8'h01, 8'hFF, 8'h00, 1'b1, 1'b0};
    vt[14] = '{1'b0, 1'b0, 8'hFF, 8'h02, 1'b1, 8'h02, 8'hFF, 8'h00, 1'b1, 1'b0};
    vt[15] = '{1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 8'h02, 8'hFF, 8'h00, 1'b1, 1'b0};
    vt[16] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    vt[17] = vt[16];
    vt[18] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b0, 1'b1};
    vt[19] = vt[18];
    vt[20] = vt[18];
    vt[21] = '{1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0};
    vt[22] = '{1'b0, 1'b1, 8'h0F, 8'h3C, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0};
    vt[23] = '{1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h3C, 8'h00, 8'hF0, 1'b0, 1'b1};
    vt[24] = '{1'b0, 1'b1, 8'h00, 8'h5A, 1'b1, 8'h00, 8'h00, 8'hFF, 1'b1, 1'b0};
    vt[25] = '{1'b0, 1'b0, 8'h00, 8'h5A, 1'b1, 8'h5A, 8'h00, 8'hFF, 1'b1, 1'b0};
    vt[26] = vt[25];

    ext = '0;
    for (int i = 0; i < NV; i++) begin
      reset            = vt[i].rst;
      req_if.req_valid = vt[i].vld;
      req_if.req_dir   = vt[i].dir;
      req_if.req_data  = vt[i].data;
      @(negedge clock);
      if (vt[i].chk) begin
        check($sformatf("vec%0d cell_o", i), cell_o, vt[i].o);
        check($sformatf("vec%0d cell_oe", i), cell_oe, vt[i].oe);
        check($sformatf("vec%0d cell_ie", i), cell_ie, vt[i].ie);
        check($sformatf("vec%0d req_ready", i), req_if.req_ready, vt[i].rdy);
        check($sformatf("vec%0d busy", i), busy, vt[i].bsy);
        check($sformatf("vec%0d rd/rise/fall", i), {rd_data, rise_evt, fall_evt}, 24'h0);
      end
      @(posedge clock); #1;
    end
    req_if.req_valid = 1'b0;

    // Pad 3 rising, then falling edge: rd at +2, one event pulse at +3.
    ext[3] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check($sformatf("rise pad3 k%0d rd", k), rd_data[3], (k >= 2) ? 1'b1 : 1'b0);
      check($sformatf("rise pad3 k%0d evt", k), rise_evt[3], (k == 3) ? 1'b1 : 1'b0);
      @(posedge clock); #1;
    end
    ext[3] = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      check($sformatf("fall pad3 k%0d rd", k), rd_data[3], (k < 2) ? 1'b1 : 1'b0);
      check($sformatf("fall pad3 k%0d evt", k), fall_evt[3], (k == 3) ? 1'b1 : 1'b0);
      @(posedge clock); #1;
    end

    // Make pad 0 an output, then turn it back to input while its line is high.
    req_if.req_valid = 1'b1; req_if.req_dir = 8'h01; req_if.req_data = 8'h01;
    @(negedge clock);
    check("pad0 out accept ready", req_if.req_ready, 1'b1);
    @(posedge clock); #1;
    req_if.req_valid = 1'b0;
    for (int k = 0; k < TURN + SYNC + 1; k++) begin
      @(posedge clock);
    end
    #1;
    ext[0] = 1'b1;
    @(negedge clock);
    check("pad0 out oe", cell_oe, 8'h01);
    check("pad0 out ready", req_if.req_ready, 1'b1);
    check("pad0 out rd0 hidden", rd_data[0], 1'b0);
    @(posedge clock); #1;
    req_if.req_valid = 1'b1; req_if.req_dir = 8'h00; req_if.req_data = 8'h00;
    ext[1] = 1'b1;
    r0_cnt = 0; r1_cnt = 0; f_cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      r0_cnt += int'(rise_evt[0]);
      r1_cnt += int'(rise_evt[1]);
      f_cnt  += int'(fall_evt != '0);
      @(posedge clock); #1;
      req_if.req_valid = 1'b0;
    end
    @(negedge clock);
    check("turn pad0 rise count", r0_cnt, 0);
    check("steady pad1 rise count", r1_cnt, 1);
    check("turn fall count", f_cnt, 0);
    check("turn pad0 rd", rd_data[0], 1'b1);
    @(posedge clock); #1;

    // Random traffic against the reference model.
    for (int n = 0; n < 600; n++) begin
      reset            = ($urandom_range(63) == 0);
      req_if.req_valid = 1'($urandom_range(1));
      if ($urandom_range(3) == 0) req_if.req_dir = W'($urandom);
      req_if.req_data  = W'($urandom);
      ext              = ext ^ (W'($urandom) & W'($urandom) & W'($urandom));
      @(posedge clock); #1;
    end
    reset = 1'b0;
    req_if.req_valid = 1'b0;
    repeat (10) @(posedge clock);
    @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
